pc_sequencer: RTL

Fetch-side controller for the 3-stage RISC-V pipeline (Fetch / Execute / Writeback). It owns the program counter and the Fetch→Execute instruction register. It sequences fetch under run/halt/single-step control from the board, applies stall and branch-redirect requests from the Execute stage, inserts bubbles, and counts retired instructions. It sits between the instruction RAM and the Execute decode/ALU stage, replacing the free-running PC logic.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, bubble instruction and PC width.
package cpu_pkg;

  localparam int          PC_W      = 12;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch RAM port and Fetch->Execute handoff between the sequencer and the Execute stage.
interface pc_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W = cpu_pkg::PC_W
) ();

  logic [PC_W-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic [31:0]     instr_ex;
  logic [PC_W-1:0] pc_ex;
  logic            valid_ex;
  logic            stall_ex;
  logic            redirect_ex;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output fetch_pc, instr_ex, pc_ex, valid_ex,
    input  fetch_instr, stall_ex, redirect_ex, redirect_pc
  );

  modport slave (
    input  fetch_pc, instr_ex, pc_ex, valid_ex,
    output fetch_instr, stall_ex, redirect_ex, redirect_pc
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side controller: owns the PC and the F->EX register, sequences run/halt/step,
// applies Execute stall/redirect and counts retired instructions.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          PC_W = cpu_pkg::PC_W,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  pc_sequencer_if.master        bus,
  output logic                  halted,
  output logic [31:0]           instret
);

  seq_state_t      state, state_nx;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_nx;
  logic [PC_W-1:0] pc_ex_q, pc_ex_nx;
  logic [31:0]     instr_ex_q, instr_ex_nx;
  logic            valid_ex_q, valid_ex_nx;
  logic            advance;
  logic            retire;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc_q;
    pc_ex_nx    = pc_ex_q;
    instr_ex_nx = instr_ex_q;
    valid_ex_nx = valid_ex_q;

    case (state)
      HALT:    if (run) state_nx = RUN;
               else if (step) state_nx = STEP;
      RUN:     if (!run) state_nx = HALT;
      STEP:    if (bus.redirect_ex || !bus.stall_ex) state_nx = HALT;
      default: state_nx = HALT;
    endcase

    advance = (state == RUN || state == STEP) && !bus.redirect_ex && !bus.stall_ex;

    // Redirect beats stall; a halted sequencer keeps its PC but feeds bubbles.
    if (bus.redirect_ex) begin
      fetch_pc_nx = bus.redirect_pc;
      instr_ex_nx = NOP;
      valid_ex_nx = 1'b0;
    end else if (bus.stall_ex) begin
      // hold everything
    end else if (advance) begin
      instr_ex_nx = bus.fetch_instr;
      pc_ex_nx    = fetch_pc_q;
      valid_ex_nx = 1'b1;
      fetch_pc_nx = fetch_pc_q + 1'b1;
    end else begin
      instr_ex_nx = NOP;
      valid_ex_nx = 1'b0;
    end
  end

  // The instruction in EX retires when it leaves, either normally or as the branch itself.
  assign retire = valid_ex_q && (!bus.stall_ex || bus.redirect_ex);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HALT;
      halted     <= 1'b1;
      fetch_pc_q <= '0;
      pc_ex_q    <= '0;
      instr_ex_q <= NOP;
      valid_ex_q <= 1'b0;
      instret    <= '0;
    end else begin
      state      <= state_nx;
      halted     <= (state_nx == HALT);
      fetch_pc_q <= fetch_pc_nx;
      pc_ex_q    <= pc_ex_nx;
      instr_ex_q <= instr_ex_nx;
      valid_ex_q <= valid_ex_nx;
      instret    <= instret + {31'd0, retire};
    end
  end

  assign bus.fetch_pc = fetch_pc_q;
  assign bus.pc_ex    = pc_ex_q;
  assign bus.instr_ex = instr_ex_q;
  assign bus.valid_ex = valid_ex_q;

endmodule
